// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: 16-bit dividend / 8-bit divisor.
// One quotient bit per cycle; Start/Halt handshake.
module seq_divider #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Dividend,
  input  logic [7:0]  Divisor,
  output logic [7:0]  Quotient,
  output logic [7:0]  Remainder,
  output logic        Halt,
  output logic        Busy,
  output logic        DivByZero,
  output logic        Overflow
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [15:0] dd_q, dd_nx;
  logic [7:0]  dv_q, dv_nx;
  logic [7:0]  acc, acc_nx;
  logic [7:0]  quo, quo_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        sd, sd_nx;
  logic        sq, sq_nx;
  logic [7:0]  q_nx, r_nx;
  logic        dbz_nx, ovf_nx;

  logic [15:0] mag_dd;
  logic [7:0]  dv_mag;
  logic [8:0]  a_sh;
  logic        ge;
  logic        ovf_fix;

  // Magnitudes are taken from the captured operands, never the live ports.
  always_comb begin
    mag_dd = dd_q;
    if (SIGNED && dd_q[15]) mag_dd = ~dd_q + 16'd1;
    dv_mag = dv_q;
    if (SIGNED && dv_q[7]) dv_mag = ~dv_q + 8'd1;
    a_sh = {acc, quo[7]};
    ge = (a_sh >= {1'b0, dv_mag});
    ovf_fix = SIGNED &&
      (sq ? (quo > 8'd128) : (quo > 8'd127));
  end

  always_comb begin
    state_nx = state;
    dd_nx    = dd_q;
    dv_nx    = dv_q;
    acc_nx   = acc;
    quo_nx   = quo;
    cnt_nx   = cnt;
    sd_nx    = sd;
    sq_nx    = sq;
    q_nx     = Quotient;
    r_nx     = Remainder;
    dbz_nx   = DivByZero;
    ovf_nx   = Overflow;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          dd_nx    = Dividend;
          dv_nx    = Divisor;
          dbz_nx   = 1'b0;
          ovf_nx   = 1'b0;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        sd_nx = SIGNED && dd_q[15];
        sq_nx = SIGNED && (dd_q[15] ^ dv_q[7]);
        if (dv_q == 8'd0) begin
          dbz_nx   = 1'b1;
          q_nx     = 8'd0;
          r_nx     = 8'd0;
          state_nx = DONE;
        end else if (mag_dd[15:8] >= dv_mag) begin
          ovf_nx   = 1'b1;
          q_nx     = 8'd0;
          r_nx     = 8'd0;
          state_nx = DONE;
        end else begin
          acc_nx   = mag_dd[15:8];
          quo_nx   = mag_dd[7:0];
          cnt_nx   = 3'd0;
          state_nx = ITER;
        end
      end
      ITER: begin
        // a_sh < 2*|divisor|, so the difference always fits 8 bits
        if (ge) acc_nx = a_sh[7:0] - dv_mag;
        else    acc_nx = a_sh[7:0];
        quo_nx = {quo[6:0], ge};
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) state_nx = FIX;
      end
      FIX: begin
        if (ovf_fix) begin
          ovf_nx = 1'b1;
          q_nx   = 8'd0;
          r_nx   = 8'd0;
        end else begin
          q_nx = sq ? (~quo + 8'd1) : quo;
          r_nx = sd ? (~acc + 8'd1) : acc;
        end
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      dd_q      <= '0;
      dv_q      <= '0;
      acc       <= '0;
      quo       <= '0;
      cnt       <= '0;
      sd        <= 1'b0;
      sq        <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      dd_q      <= dd_nx;
      dv_q      <= dv_nx;
      acc       <= acc_nx;
      quo       <= quo_nx;
      cnt       <= cnt_nx;
      sd        <= sd_nx;
      sq        <= sq_nx;
      Quotient  <= q_nx;
      Remainder <= r_nx;
      DivByZero <= dbz_nx;
      Overflow  <= ovf_nx;
    end
  end

  assign Halt = (state == DONE);
  assign Busy = (state == LOAD) || (state == ITER) ||
                (state == FIX);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, scoreboard queue,
// hand sequences for held Start and mid-operation reset.
module tb_seq_divider;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;

  logic [7:0] s_quo, s_rem, u_quo, u_rem;
  logic       s_halt, s_busy, s_dbz, s_ovf;
  logic       u_halt, u_busy, u_dbz, u_ovf;

  always #5 Clock = ~Clock;

  seq_divider #(.SIGNED(1'b1)) u_s (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(s_quo), .Remainder(s_rem),
    .Halt(s_halt), .Busy(s_busy),
    .DivByZero(s_dbz), .Overflow(s_ovf)
  );

  seq_divider #(.SIGNED(1'b0)) u_u (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(u_quo), .Remainder(u_rem),
    .Halt(u_halt), .Busy(u_busy),
    .DivByZero(u_dbz), .Overflow(u_ovf)
  );

  typedef struct {
    bit          sgn;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    bit          dbz;
    bit          ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    bit         dbz;
    bit         ovf;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " halt"}, s_halt, 0);
    check({tag, " busy"}, s_busy, 0);
    check({tag, " quo"},  s_quo,  0);
    check({tag, " rem"},  s_rem,  0);
    check({tag, " dbz"},  s_dbz,  0);
    check({tag, " ovf"},  s_ovf,  0);
    check({tag, " u_quo"}, u_quo, 0);
  endtask

  task automatic run_op(input bit sgn,
                        input logic [15:0] dd,
                        input logic [7:0] dv,
                        input exp_t e,
                        input int lat,
                        input int hold,
                        input string tag);
    int   edges, busy, wait_n;
    bit   got;
    exp_t x;
    Dividend = dd;
    Divisor  = dv;
    Start    = 1'b1;
    sb.push_back(e);
    @(posedge Clock); #1;
    edges = 1;
    busy  = 0;
    got   = 1'b0;
    while (edges < 40) begin
      if (edges >= hold) Start = 1'b0;
      else Dividend = 16'($urandom);
      if (sgn ? s_busy : u_busy) busy++;
      if (sgn ? s_halt : u_halt) begin
        got = 1'b1;
        break;
      end
      @(posedge Clock); #1;
      edges++;
    end
    Start = 1'b0;
    check({tag, " halt_seen"}, got, 1);
    check({tag, " latency"}, edges, lat);
    check({tag, " busy_cycles"}, busy, lat - 1);
    x = sb.pop_front();
    check({tag, " quo"}, sgn ? s_quo : u_quo, x.q);
    check({tag, " rem"}, sgn ? s_rem : u_rem, x.r);
    check({tag, " dbz"}, sgn ? s_dbz : u_dbz, x.dbz);
    check({tag, " ovf"}, sgn ? s_ovf : u_ovf, x.ovf);
    wait_n = 0;
    while (!(s_halt && u_halt) && wait_n < 20) begin
      @(posedge Clock); #1;
      wait_n++;
    end
    if (wait_n >= 20) check({tag, " both_idle"}, 0, 1);
  endtask

  initial begin
    exp_t e;
    logic [7:0]  a, b;
    logic [15:0] p;

    vt.push_back('{1'b1, 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2});
    vt.push_back('{1'b1, 16'hFC00, 8'h08, 8'h80, 8'h00, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'h0400, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 11});
    vt.push_back('{1'b1, 16'h7F00, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 2});
    vt.push_back('{1'b0, 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'h8000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 2});
    vt.push_back('{1'b1, 16'hFF81, 8'h01, 8'h81, 8'h00, 1'b0, 1'b0, 11});
    vt.push_back('{1'b0, 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'h0005, 8'hF9, 8'h00, 8'h05, 1'b0, 1'b0, 11});
    vt.push_back('{1'b1, 16'hFFFB, 8'h07, 8'h00, 8'hFB, 1'b0, 1'b0, 11});
    vt.push_back('{1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2});

    Reset    = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_zero("reset");

    foreach (vt[i]) begin
      e = '{vt[i].q, vt[i].r, vt[i].dbz, vt[i].ovf};
      run_op(vt[i].sgn, vt[i].dd, vt[i].dv, e, vt[i].lat, 1,
             $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      p = 16'(a) * 16'(b);
      e = '{a, 8'h00, 1'b0, 1'b0};
      run_op(1'b0, p, b, e, 11, 1, $sformatf("rt%0d", k));
    end

    e = '{8'h0E, 8'h02, 1'b0, 1'b0};
    run_op(1'b1, 16'h0064, 8'h07, e, 11, 11, "held_start");
    repeat (3) @(posedge Clock);
    #1;
    check("hold halt", s_halt, 1);
    check("hold quo", s_quo, 8'h0E);
    check("hold rem", s_rem, 8'h02);

    Dividend = 16'h00C8;
    Divisor  = 8'h09;
    Start    = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    check("midop busy", s_busy, 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check_zero("midop_reset");

    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    Start = 1'b0;
    check_zero("reset_start");
    @(posedge Clock); #1;
    check("reset_wins busy", s_busy, 0);

    e = '{8'h16, 8'h02, 1'b0, 1'b0};
    run_op(1'b1, 16'h00C8, 8'h09, e, 11, 1, "after_reset");

    check("sb empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed/unsigned divider that inverts the shift-add multiplier datapath: 16-bit dividend / 8-bit divisor -> 8-bit quotient and 8-bit remainder.
- Uses a restoring shift-subtract algorithm with one quotient bit per cycle.
- Driven by a Start/Halt handshake so the term-project controller can chain multiply and divide operations.
- Product from the multiplier feeds Dividend directly for round-trip checks.

Parameters:
SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high; one clock; returns block to IDLE
Start  input  1  request; sampled only in IDLE or DONE
Dividend  input  16  dividend; captured on accepted Start
Divisor  input  8  divisor; captured on accepted Start
Quotient  output  8  registered result
Remainder  output  8  registered result
Halt  output  1  high while in DONE (result valid)
Busy  output  1  high in LOAD, ITER, FIX
DivByZero  output  1  error flag, valid with Halt
Overflow  output  1  quotient not representable in 8 bits; valid with Halt

Behaviour:
- Reset (sync): state=IDLE; Quotient, Remainder, Halt, Busy, DivByZero, Overflow all 0; iteration counter 0.
- States: IDLE -> LOAD -> ITER (8 cycles) -> FIX -> DONE; DONE -> LOAD on Start, otherwise stays in DONE.
- IDLE/DONE with Start=1: capture operands, clear flags, go to LOAD. Halt drops on that edge.
- Start in LOAD/ITER/FIX is ignored; captured operands do not change.
- LOAD:
  - SIGNED=1: record sign of dividend (sD) and quotient sign (sD xor sDivisor). Take 16-bit unsigned magnitudes; |-32768| = 0x8000, |-128| = 0x80.
  - Divisor==0: DivByZero=1, go to DONE.
  - Else if magnitude of dividend[15:8] >= |divisor|: Overflow=1, go to DONE.
  - Else load A = magnitude of dividend[15:8] (9 bits, with guard bit), Q = magnitude of dividend[7:0], count=0, go to ITER.
- ITER (each cycle):
  - Shift {A,Q} left 1.
  - T = A - {0,|divisor|}.
  - If T >= 0: A = T and Q[0] = 1; else Q[0] = 0.
  - count++. After count==7, go to FIX.
- FIX:
  - SIGNED=1:
    - Quotient = negate(Q) if the quotient sign is negative.
    - Remainder = negate(A[7:0]) if sD is set.
    - Overflow=1 if magnitude Q > 127 with positive quotient sign, or > 128 with negative quotient sign.
  - SIGNED=0: Quotient = Q, Remainder = A[7:0].
  - Go to DONE.
- Error results: on DivByZero or Overflow, Quotient=0 and Remainder=0.
- Rounding: quotient truncates toward zero; remainder carries the dividend's sign; Quotient*Divisor + Remainder == Dividend whenever no flag is set.
- Latency: count edges after the edge that accepts Start.
  - Normal operation: Halt=1 after edge 11 (LOAD 1 + ITER 8 + FIX 1 + DONE entry).
  - Error detected in LOAD: Halt=1 after edge 2.
- Outputs hold their value through DONE and are overwritten only at FIX or at error exit from LOAD of the next operation.
- Reset mid-operation: abort immediately; all outputs return to reset values on that edge.
- Reset and Start in the same cycle: Reset wins.

Test Plan:
1. SIGNED=1, Dividend=0x0064 (100), Divisor=0x07 -> Quotient=0x0E, Remainder=0x02, flags 0; Halt rises exactly 11 edges after the Start edge; Busy high for 10 cycles.
2. Dividend=0xFF9C (-100), Divisor=0x07 -> Quotient=0xF2 (-14), Remainder=0xFE (-2). Dividend=0x0064, Divisor=0xF9 (-7) -> Quotient=0xF2, Remainder=0x02.
3. Divisor=0x00, any dividend -> DivByZero=1, Quotient=Remainder=0, Halt after 2 edges; Start pulsed in DONE starts a new operation.
4. Dividend=0xFC00 (-1024), Divisor=0x08 -> Quotient=0x80, Overflow=0. Dividend=0x0400 (1024), Divisor=0x08 -> Overflow=1, outputs 0. Dividend=0x7F00, Divisor=0x10 -> Overflow=1 from LOAD, Halt after 2 edges.
5. SIGNED=0: Dividend=0xFEFF, Divisor=0xFF -> Quotient=0xFF, Remainder=0xFE. Round-trip: random 8x8 products fed back with the nonzero multiplier as divisor -> exact quotient, Remainder=0.
6. Start held high throughout ITER -> no restart, results unchanged. Reset asserted at ITER count 4 -> IDLE next edge, all outputs 0, next Start yields a correct result.
